// File: rtl/regfile_mp_sb_pkg.sv
// Shared types and defaults for the multi-port register file with busy scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_REG     = 0;

  // Keeps the address at least one bit wide even for a 2-entry file.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ADDR_W_DEF = addr_w(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of regfile_mp_sb: read ports, write ports, scoreboard.
interface regfile_mp_sb_if import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int ADDR_W = addr_w(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic [NUM_REGS-1:0]      busy_vec;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, busy_vec, wr_conflict
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, busy_vec, wr_conflict
  );
endinterface

// File: rtl/regfile_mp_sb_wr_arbiter.sv
// Resolves write ports into per-register enables/data (highest index wins) and
// flags two or more enabled ports hitting one nonzero register.
module regfile_wr_arbiter import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 2,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic [NUM_WR-1:0]                i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]         i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]         i_wr_data,
  output logic [NUM_REGS-1:0]              o_we,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  o_wdata,
  output logic                             o_conflict
);
  logic w_hit;

  always_comb begin
    o_we       = '0;
    o_wdata    = '0;
    o_conflict = 1'b0;
    w_hit      = 1'b0;
    // Register 0 is skipped so its writes vanish and never count as a conflict.
    for (int r = ZERO_REG + 1; r < NUM_REGS; r++) begin
      w_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          if (w_hit) o_conflict = 1'b1;
          w_hit      = 1'b1;
          o_we[r]    = 1'b1;
          o_wdata[r] = i_wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// N-read/M-write register file, x0 hardwired to zero, with a per-register busy
// scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  regfile_mp_sb_if.slave   bus
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_busy;
  logic                            r_conflict;

  logic [NUM_REGS-1:0]             w_we;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_wdata;
  logic                            w_conflict;
  logic [NUM_REGS-1:0]             w_set;
  logic [NUM_RD*DATA_W-1:0]        w_rd_data;
  logic [NUM_RD-1:0]               w_rd_busy;

  regfile_wr_arbiter #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_arb (
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .o_we       (w_we),
    .o_wdata    (w_wdata),
    .o_conflict (w_conflict)
  );

  always_comb begin
    w_set = '0;
    for (int r = ZERO_REG + 1; r < NUM_REGS; r++)
      w_set[r] = bus.sb_set_en && (bus.sb_set_addr == ADDR_W'(r));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs     <= '0;
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
      for (int r = ZERO_REG + 1; r < NUM_REGS; r++) begin
        if (w_we[r]) r_regs[r] <= w_wdata[r];
        // A new producer issuing in the same cycle keeps the register busy.
        if (w_set[r])     r_busy[r] <= 1'b1;
        else if (w_we[r]) r_busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
      if (w_we[bus.rd_addr[i*ADDR_W +: ADDR_W]]) begin
        w_rd_data[i*DATA_W +: DATA_W] = w_wdata[bus.rd_addr[i*ADDR_W +: ADDR_W]];
        w_rd_busy[i]                  = w_set[bus.rd_addr[i*ADDR_W +: ADDR_W]];
      end else begin
        w_rd_data[i*DATA_W +: DATA_W] = r_regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
        w_rd_busy[i]                  = r_busy[bus.rd_addr[i*ADDR_W +: ADDR_W]];
      end
`else
      w_rd_data[i*DATA_W +: DATA_W] = r_regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
      w_rd_busy[i]                  = r_busy[bus.rd_addr[i*ADDR_W +: ADDR_W]];
`endif
    end
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.busy_vec    = r_busy;
  assign bus.wr_conflict = r_conflict;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (default 32x32, 2 read / 2 write ports).
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if bus ();
  regfile_mp_sb u_dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    // reset and x0
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy_vec", bus.busy_vec, 32'h0);
    chk("rst_conflict", {31'h0, bus.wr_conflict}, 32'h0);
    for (int a = 0; a < 32; a += 2) begin
      bus.rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk($sformatf("rst_rd0_x%0d", a), bus.rd_data[31:0], 32'h0);
      chk($sformatf("rst_rd1_x%0d", a + 1), bus.rd_data[63:32], 32'h0);
    end
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd0}; bus.wr_data = {32'h0, 32'hDEADBEEF};
    bus.rd_addr = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    chk("x0_write_dropped", bus.rd_data[31:0], 32'h0);
    chk("x0_busy", {31'h0, bus.rd_busy[0]}, 32'h0);

    // basic dual write
    bus.wr_en = 2'b11; bus.wr_addr = {5'd9, 5'd5}; bus.wr_data = {32'hFFFF0000, 32'h00001234};
    tick();
    idle();
    bus.rd_addr = {5'd9, 5'd5};
    #1;
    chk("basic_rd0_x5", bus.rd_data[31:0], 32'h00001234);
    chk("basic_rd1_x9", bus.rd_data[63:32], 32'hFFFF0000);
    chk("basic_no_conflict", {31'h0, bus.wr_conflict}, 32'h0);

    // collision: port 1 wins, conflict pulses one cycle
    bus.wr_en = 2'b11; bus.wr_addr = {5'd7, 5'd7}; bus.wr_data = {32'h22, 32'h11};
    tick();
    idle();
    bus.rd_addr = {5'd5, 5'd7};
    #1;
    chk("coll_x7", bus.rd_data[31:0], 32'h22);
    chk("coll_flag_set", {31'h0, bus.wr_conflict}, 32'h1);
    tick();
    chk("coll_flag_clear", {31'h0, bus.wr_conflict}, 32'h0);
    chk("coll_x7_hold", bus.rd_data[31:0], 32'h22);
    // both ports on x0: no conflict
    bus.wr_en = 2'b11; bus.wr_addr = {5'd0, 5'd0}; bus.wr_data = {32'h1, 32'h2};
    tick();
    idle();
    #1;
    chk("coll_x0_no_flag", {31'h0, bus.wr_conflict}, 32'h0);

    // scoreboard
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd4;
    tick();
    idle();
    bus.rd_addr = {5'd5, 5'd4};
    #1;
    chk("sb_busy_x4", {31'h0, bus.rd_busy[0]}, 32'h1);
    chk("sb_busy_vec", bus.busy_vec, 32'h0000_0010);
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd4}; bus.wr_data = {32'h0, 32'h33};
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd4;
    #1;
    chk("sb_set_clr_comb_busy", {31'h0, bus.rd_busy[0]}, 32'h1);
    tick();
    idle();
    #1;
    chk("sb_set_wins", {31'h0, bus.rd_busy[0]}, 32'h1);
    chk("sb_x4_data", bus.rd_data[31:0], 32'h33);
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd4}; bus.wr_data = {32'h0, 32'h44};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("sb_clr_comb_busy", {31'h0, bus.rd_busy[0]}, 32'h0);
    chk("sb_clr_comb_data", bus.rd_data[31:0], 32'h44);
`else
    chk("sb_clr_comb_busy", {31'h0, bus.rd_busy[0]}, 32'h1);
    chk("sb_clr_comb_data", bus.rd_data[31:0], 32'h33);
`endif
    tick();
    idle();
    #1;
    chk("sb_cleared", {31'h0, bus.rd_busy[0]}, 32'h0);
    chk("sb_x4_new", bus.rd_data[31:0], 32'h44);
    chk("sb_vec_empty", bus.busy_vec, 32'h0);
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd0;
    tick();
    idle();
    #1;
    chk("sb_x0_ignored", bus.busy_vec, 32'h0);

    // same-cycle write/read of x3
    bus.rd_addr = {5'd9, 5'd3};
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd3}; bus.wr_data = {32'h0, 32'h0000CAFE};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_x3", bus.rd_data[31:0], 32'h0000CAFE);
`else
    chk("byp_x3", bus.rd_data[31:0], 32'h0);
`endif
    tick();
    idle();
    #1;
    chk("byp_x3_stored", bus.rd_data[31:0], 32'h0000CAFE);
    bus.wr_en = 2'b11; bus.wr_addr = {5'd3, 5'd3}; bus.wr_data = {32'h2, 32'h1};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_high_wins", bus.rd_data[31:0], 32'h2);
`else
    chk("byp_high_wins", bus.rd_data[31:0], 32'h0000CAFE);
`endif
    tick();
    idle();
    #1;
    chk("byp_x3_final", bus.rd_data[31:0], 32'h2);

    // reset mid-operation
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd6}; bus.wr_data = {32'h0, 32'h66};
    tick();
    idle();
    reset = 1'b1;
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd6}; bus.wr_data = {32'h0, 32'h77};
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd6;
    tick();
    reset = 1'b0;
    idle();
    bus.rd_addr = {5'd5, 5'd6};
    #1;
    chk("rstmid_x6", bus.rd_data[31:0], 32'h0);
    chk("rstmid_x5", bus.rd_data[63:32], 32'h0);
    chk("rstmid_busy", bus.busy_vec, 32'h0);
    chk("rstmid_conflict", {31'h0, bus.wr_conflict}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file for the next multi-cycle/pipelined datapath. It generalises the single-write, two-read file to N read ports and M write ports, with a per-register busy scoreboard for hazard detection. Register 0 is hardwired to zero. It sits between decode (read and scoreboard set) and writeback (write and scoreboard clear).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, ≥2)
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)
NUM_RD, 2, number of read ports (≥1)
NUM_WR, 2, number of write ports (≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  scoreboard busy bit of each read address
wr_en  in  NUM_WR  write enable per write port
wr_addr  in  NUM_WR*ADDR_W  packed write addresses
wr_data  in  NUM_WR*DATA_W  packed write data
sb_set_en  in  1  mark a destination register busy (instruction issued)
sb_set_addr  in  ADDR_W  register to mark busy
busy_vec  out  NUM_REGS  full scoreboard, bit r = register r busy
wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same nonzero address last cycle

Behaviour:
- Reset is synchronous and active-high on clk. On a reset edge all registers become 0, busy_vec becomes 0, and wr_conflict becomes 0. Reset overrides every write and scoreboard input in the same cycle.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = busy_vec[rd_addr[i]]. Address 0 always reads 0 with busy 0.
- Writes commit on the rising edge when wr_en[j]=1 and wr_addr[j]≠0. Writes to address 0 are dropped silently.
- Same-cycle write collision on one address: the highest-index enabled port wins. wr_conflict is 1 in the following cycle only, then returns to 0.
- Scoreboard set: sb_set_en=1 with sb_set_addr≠0 sets busy[sb_set_addr] at the edge. Setting an already-busy register leaves it busy; there is no counting.
- Scoreboard clear: any committed write to register r clears busy[r] at the same edge.
- Set and clear of the same register in the same cycle: the set wins, so busy stays 1 (a new producer has issued).
- Read latency is 0 cycles. A write becomes visible 1 cycle after its edge, unless the optional feature below is enabled.
- Reset asserted mid-operation discards in-flight writes and sets, with no partial state.
- Only registers and busy bits are stored; there is no FSM beyond scoreboard bit state (each bit idle→busy on set, busy→idle on write).

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If an enabled write port (nonzero address) matches rd_addr[i] in the current cycle, rd_data[i] returns that port's wr_data, using highest-index-wins. rd_busy[i] reads 0 unless sb_set_en targets the same address in that cycle, in which case it reads 1.
- Undefined: rd_data and rd_busy reflect stored state only, i.e. the pre-edge value.

Decomposition:
- Package regfile_pkg holds:
  - the DATA_W and NUM_REGS defaults;
  - function clog2-safe addr width;
  - typedef reg_addr_t (logic [ADDR_W-1:0]);
  - typedef reg_data_t;
  - localparam ZERO_REG = 0.
- One sub-module is natural: regfile_wr_arbiter. It takes wr_en/wr_addr/wr_data and outputs a per-register write-enable plus selected data (highest-index-wins) and the conflict detect. The same logic is reused for the bypass mux.

Test Plan:
- Reset and x0: assert reset 1 cycle, then read all addresses → all rd_data 0 and busy_vec 0; write 32'hDEADBEEF to x0 via port 0 → rd_data still 0.
- Basic write/read: port0 writes x5=32'h0000_1234 and port1 writes x9=32'hFFFF_0000 in one cycle → next cycle rd0(x5)=32'h1234 and rd1(x9)=32'hFFFF0000.
- Collision: port0 writes x7=32'h11 and port1 writes x7=32'h22 in the same cycle → x7=32'h22 and wr_conflict=1 for exactly one cycle.
- Scoreboard: set x4 → rd_busy for x4 reads 1; the cycle after, write x4 while sb_set x4 → still busy; next write x4 with no set → busy 0.
- Bypass: write x3=32'hCAFE while reading x3 in the same cycle → 32'hCAFE when REGFILE_BYPASS_EN is defined, else the old value 0.
- Reset mid-op: reset together with a write to x6 and sb_set x6 → x6=0 and busy 0.
